frog_game_sequencer: RTL and testbench

- Top-level game-flow controller for the frog datapath.
- Sequences start, play, death (skull display), respawn, level-up and game-over.
- Owns lives, level and the round countdown.
- Drives the respawn/skull/halt/timer_stop controls consumed by the frog motion block and the HUD/VGA logic; all hazard inputs come from the collision/water/home detectors.

---
 rtl/frog_game_sequencer.sv | 161 ++++++++++++++++
 tb/tb_frog_game_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/frog_game_sequencer.sv
// Game-flow controller for the frog datapath: start, play, death, respawn, level-up, game-over.
// Define PAUSE_EN to enable the 'P' key PLAY<->PAUSED toggle (state 6).
module frog_game_sequencer #(
    parameter int START_LIVES = 3,
    parameter int SKULL_TICKS = 36,
    parameter int TIME_INIT   = 60,
    parameter int TIME_DIV    = 60,
    parameter int MAX_LEVEL   = 7
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [15:0] keycode,
    input  logic        collision,
    input  logic        in_water,
    input  logic        success,
    output logic [2:0]  state,
    output logic [2:0]  lives,
    output logic [2:0]  level,
    output logic [6:0]  time_left,
    output logic        respawn,
    output logic        skull,
    output logic        halt,
    output logic        timer_stop,
    output logic        game_over
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PLAY     = 3'd1;
    localparam logic [2:0] S_DYING    = 3'd2;
    localparam logic [2:0] S_RESPAWN  = 3'd3;
    localparam logic [2:0] S_LEVEL_UP = 3'd4;
    localparam logic [2:0] S_OVER     = 3'd5;
    localparam logic [2:0] S_PAUSED   = 3'd6;

    localparam int TICK_W  = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam int SKULL_W = (SKULL_TICKS > 1) ? $clog2(SKULL_TICKS) : 1;

    localparam logic [15:0] KEY_SPACE = 16'h002C;

    logic [15:0]        prev_key;
    logic [TICK_W-1:0]  tick_cnt, tick_cnt_n;
    logic [SKULL_W-1:0] skull_cnt, skull_cnt_n;
    logic [2:0]         state_n, lives_n, level_n;
    logic [6:0]         time_n;
    logic               start_edge, pause_edge, reload;

    assign start_edge = (keycode == KEY_SPACE) && (prev_key != KEY_SPACE);

`ifdef PAUSE_EN
    localparam logic [15:0] KEY_P = 16'h0013;
    assign pause_edge = (keycode == KEY_P) && (prev_key != KEY_P);
`else
    assign pause_edge = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_n     = state;
        lives_n     = lives;
        level_n     = level;
        time_n      = time_left;
        tick_cnt_n  = tick_cnt;
        skull_cnt_n = skull_cnt;
        reload      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    lives_n    = 3'(START_LIVES);
                    level_n    = 3'd0;
                    time_n     = 7'(TIME_INIT);
                    tick_cnt_n = '0;
                    reload     = 1'b1;
                    state_n    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (pause_edge) begin
                    state_n = S_PAUSED;
                end else if (frame_tick) begin
                    // Hazard beats success, success beats timeout.
                    if (collision || in_water || (!success && time_left == 7'd0)) begin
                        lives_n     = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                        skull_cnt_n = '0;
                        state_n     = S_DYING;
                    end else if (success) begin
                        state_n = S_LEVEL_UP;
                    end else if (tick_cnt == TICK_W'(TIME_DIV - 1)) begin
                        tick_cnt_n = '0;
                        time_n     = time_left - 7'd1;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (skull_cnt == SKULL_W'(SKULL_TICKS - 1))
                        state_n = (lives == 3'd0) ? S_OVER : S_RESPAWN;
                    else
                        skull_cnt_n = skull_cnt + 1'b1;
                end
            end
            S_RESPAWN: begin
                time_n     = 7'(TIME_INIT);
                tick_cnt_n = '0;
                state_n    = S_PLAY;
            end
            S_LEVEL_UP: begin
                if (level < 3'(MAX_LEVEL))
                    level_n = level + 3'd1;
                time_n     = 7'(TIME_INIT);
                tick_cnt_n = '0;
                state_n    = S_PLAY;
            end
            S_OVER: begin
                lives_n = 3'd0;
                if (start_edge)
                    state_n = S_IDLE;
            end
            S_PAUSED: begin
                if (pause_edge)
                    state_n = S_PLAY;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            lives      <= 3'(START_LIVES);
            level      <= 3'd0;
            time_left  <= 7'(TIME_INIT);
            tick_cnt   <= '0;
            skull_cnt  <= '0;
            prev_key   <= 16'h0000;
            respawn    <= 1'b0;
            skull      <= 1'b0;
            halt       <= 1'b1;
            timer_stop <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            lives      <= lives_n;
            level      <= level_n;
            time_left  <= time_n;
            tick_cnt   <= tick_cnt_n;
            skull_cnt  <= skull_cnt_n;
            prev_key   <= keycode;
            // Outputs are registered from the next state so they align with the state register.
            respawn    <= reload || (state_n == S_RESPAWN) || (state_n == S_LEVEL_UP);
            skull      <= (state_n == S_DYING);
            halt       <= (state_n != S_PLAY);
            timer_stop <= (state_n == S_IDLE) || (state_n == S_OVER) || (state_n == S_PAUSED);
            game_over  <= (state_n == S_OVER);
        end
    end

endmodule

// File: tb/tb_frog_game_sequencer.sv
// Directed self-checking bench for frog_game_sequencer (default build, PAUSE_EN undefined).
module tb_frog_game_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        collision = 1'b0;
    logic        in_water = 1'b0;
    logic        success = 1'b0;
    logic [2:0]  state, lives, level;
    logic [6:0]  time_left;
    logic        respawn, skull, halt, timer_stop, game_over;

    int n_checks = 0;
    int n_pass = 0;
    int resp_total = 0;
    int resp_mark = 0;

    frog_game_sequencer dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
        .collision(collision), .in_water(in_water), .success(success),
        .state(state), .lives(lives), .level(level), .time_left(time_left),
        .respawn(respawn), .skull(skull), .halt(halt), .timer_stop(timer_stop),
        .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    // Counts respawn-high cycles; sampled mid-cycle.
    always @(negedge Clk) if (respawn === 1'b1) resp_total++;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Each frame: one tick cycle followed by one idle cycle.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_state"},      32'(state),      0);
        check({pfx, "_lives"},      32'(lives),      3);
        check({pfx, "_level"},      32'(level),      0);
        check({pfx, "_time"},       32'(time_left),  60);
        check({pfx, "_halt"},       32'(halt),       1);
        check({pfx, "_timer_stop"}, 32'(timer_stop), 1);
        check({pfx, "_skull"},      32'(skull),      0);
        check({pfx, "_respawn"},    32'(respawn),    0);
        check({pfx, "_game_over"},  32'(game_over),  0);
    endtask

    initial begin
        #1 Reset = 1'b1;
        #1 check_reset_values("rst");
        step();
        Reset = 1'b0;
        step();

        // Start: space held for 10 frames gives one respawn pulse.
        resp_mark = resp_total;
        keycode = 16'h002C;
        frames(10);
        check("start_state", 32'(state), 1);
        check("start_lives", 32'(lives), 3);
        check("start_time", 32'(time_left), 60);
        check("start_halt", 32'(halt), 0);
        check("start_timer_stop", 32'(timer_stop), 0);
        check("start_resp_cnt", 32'(resp_total - resp_mark), 1);
        keycode = 16'h0000;
        step();

        // Collision -> DYING for 36 ticks, hazards ignored, then RESPAWN -> PLAY.
        resp_mark = resp_total;
        collision = 1'b1;
        frames(1);
        check("die1_state", 32'(state), 2);
        check("die1_lives", 32'(lives), 2);
        check("die1_skull", 32'(skull), 1);
        check("die1_halt", 32'(halt), 1);
        frames(9);
        check("die1_ignore_lives", 32'(lives), 2);
        collision = 1'b0;
        frames(26);
        check("die1_tick35_state", 32'(state), 2);
        check("die1_tick35_skull", 32'(skull), 1);
        frames(1);
        check("die1_exit_state", 32'(state), 1);
        check("die1_exit_skull", 32'(skull), 0);
        check("die1_exit_time", 32'(time_left), 60);
        check("die1_resp_cnt", 32'(resp_total - resp_mark), 1);

        // Countdown boundary, then collision+success on one tick.
        frames(59);
        check("cd_59_time", 32'(time_left), 60);
        frames(1);
        check("cd_60_time", 32'(time_left), 59);
        collision = 1'b1;
        success = 1'b1;
        frames(1);
        check("both_state", 32'(state), 2);
        check("both_lives", 32'(lives), 1);
        check("both_level", 32'(level), 0);
        collision = 1'b0;
        success = 1'b0;
        frames(36);
        check("both_exit_state", 32'(state), 1);
        check("both_exit_time", 32'(time_left), 60);
        check("both_exit_level", 32'(level), 0);

        // Timeout: 3600 ticks drain the timer, next tick kills.
        frames(3600);
        check("to_time0", 32'(time_left), 0);
        check("to_still_play", 32'(state), 1);
        frames(1);
        check("to_state", 32'(state), 2);
        check("to_lives", 32'(lives), 0);
        resp_mark = resp_total;
        frames(35);
        check("to_tick35_state", 32'(state), 2);
        frames(1);
        check("over_state", 32'(state), 5);
        check("over_game_over", 32'(game_over), 1);
        check("over_lives", 32'(lives), 0);
        check("over_halt", 32'(halt), 1);
        check("over_timer_stop", 32'(timer_stop), 1);
        check("over_resp_cnt", 32'(resp_total - resp_mark), 0);
        frames(3);
        check("over_hold", 32'(state), 5);

        // Space -> IDLE, space again -> PLAY with fresh lives/level.
        keycode = 16'h002C;
        step();
        check("over_to_idle", 32'(state), 0);
        check("idle_game_over", 32'(game_over), 0);
        keycode = 16'h0000;
        step();
        keycode = 16'h002C;
        step();
        check("restart_state", 32'(state), 1);
        check("restart_lives", 32'(lives), 3);
        check("restart_level", 32'(level), 0);
        check("restart_time", 32'(time_left), 60);
        check("restart_respawn", 32'(respawn), 1);
        step();
        check("restart_resp_one", 32'(respawn), 0);
        keycode = 16'h0000;
        step();

        // Eight successes: level saturates at 7, lives unchanged.
        resp_mark = resp_total;
        success = 1'b1;
        frames(1);
        check("lvl1_state", 32'(state), 1);
        check("lvl1_level", 32'(level), 1);
        frames(6);
        check("lvl7_level", 32'(level), 7);
        frames(1);
        check("lvl8_level", 32'(level), 7);
        check("lvl8_lives", 32'(lives), 3);
        check("lvl_resp_cnt", 32'(resp_total - resp_mark), 8);
        success = 1'b0;

        // Reset asserted mid-DYING takes effect immediately.
        collision = 1'b1;
        frames(1);
        check("rd_state", 32'(state), 2);
        collision = 1'b0;
        frames(5);
        Reset = 1'b1;
        #1 check_reset_values("rd");
        step();
        Reset = 1'b0;
        frames(2);
        check("rd_stay_idle", 32'(state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
